pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
Programmable pulse-train generator, the parametrised successor of the fixed three-pulse generator. On a start request it drives a train of pulses with configurable high width, low width and count (one-shot), or runs until stopped (continuous). It is used as a stimulus and timing source for counters, latches and test benches in the guide designs. Single clock domain; all outputs are registered.

Parameters:
WIDTH_W, 8, bit width of the high_len/low_len phase-length inputs and phase counter
COUNT_W, 8, bit width of pulse_count and pulse_num

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request to begin a train; sampled only in IDLE
stop  input  1  abort request; sampled in any state
mode  input  1  0 = one-shot (pulse_count pulses), 1 = continuous
high_len  input  WIDTH_W  high-phase length in clock cycles
low_len  input  WIDTH_W  low-phase length in clock cycles
pulse_count  input  COUNT_W  number of pulses in one-shot mode
signal  output  1  pulse train output
busy  output  1  high while a train is running
done  output  1  one-cycle strobe on normal one-shot completion
err  output  1  one-cycle strobe when start is rejected
pulse_num  output  COUNT_W  pulses begun in the current/last train

Behaviour:
- Clock is "clock"; reset is "reset_n": one clock, asynchronous, active-low. While reset_n=0: state IDLE, signal=0, busy=0, done=0, err=0, pulse_num=0, phase counter=0. Reset mid-train aborts immediately, with no done.
- Notation: "cycle t" is the period after rising edge t.
- States: IDLE, HIGH, LOW.
- IDLE, start=1, stop=0:
  - Config is valid if high_len≥1, low_len≥1 and (mode=1 or pulse_count≥1).
  - Valid config: mode/lengths/count are latched; next state HIGH; signal=1 and busy=1 from the same edge; pulse_num=1; phase counter loaded with high_len-1.
  - Invalid config: err=1 for one cycle; remain IDLE.
- IDLE, start=1 and stop=1 together: stop wins; start is ignored with no err.
- HIGH: counter decrements each cycle. At counter=0 the next state is LOW, signal=0, and the counter loads low_len-1. signal stays high for exactly high_len cycles.
- LOW: counter decrements each cycle. At counter=0:
  - Continuous mode, or pulse_num < latched count: go to HIGH, signal=1, pulse_num+1, counter=high_len-1.
  - Otherwise: go to IDLE, busy=0, done=1 for one cycle.
- The final low phase is always emitted in full before done.
- Continuous mode: pulse_num wraps modulo 2^COUNT_W; there is no done.
- stop=1 while busy: next edge goes to IDLE, signal=0, busy=0, no done. pulse_num holds its value.
- start while busy is ignored. Config input changes mid-train have no effect because values are latched.
- pulse_num holds after completion and clears to 0 on the next accepted start before it is set to 1.
- done and err are never high together. done, err and busy are never all low while the state is not IDLE.

Decomposition:
- Shared package pulse_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_HIGH=2'd1, ST_LOW=2'd2
  - MODE_ONESHOT=1'b0, MODE_CONT=1'b1
- One sub-module, pulse_phase_timer (WIDTH_W): loadable down-counter with load, load_val and enable inputs and a zero flag output. Instanced once; the FSM drives load and enable.

Test Plan:
- One-shot, high_len=2, low_len=2, pulse_count=3, start at edge 0 -> signal=1 in cycles 0-1, 4-5 and 8-9, 0 elsewhere; busy=1 in cycles 0-11; done=1 only in cycle 12; pulse_num=3 after the train.
- Asymmetric one-shot, high_len=1, low_len=5, count=2 -> signal high in cycles 0 and 6 only; done in cycle 12.
- Continuous, high_len=3, low_len=1, stop asserted at edge 10 -> period-4 train with signal high in cycles 0-2, 4-6 and 8-9; from cycle 10 signal=0 and busy=0; no done; pulse_num=3.
- Invalid start, high_len=0 or (mode=0, pulse_count=0) -> err=1 for one cycle, busy stays 0, signal stays 0.
- Start during busy, and start+stop together in IDLE -> both ignored; train timing unchanged; no err.
- reset_n low asynchronously mid-HIGH, then a fresh start -> all outputs 0 at once without a clock edge; the new train has the correct timing and pulse_num restarts at 1.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared encodings for the pulse-train generator: FSM states and mode values.
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one phase (high or low) of the pulse train.
// Load has priority over counting; the counter parks at zero.
module pulse_phase_timer #(
    parameter int WIDTH_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [WIDTH_W-1:0] load_val,
    input  logic               enable,
    output logic               zero
);

    logic [WIDTH_W-1:0] cnt;

    // Load a new phase length or count the current one down to zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - WIDTH_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: one-shot (pulse_count pulses) or
// continuous, with configurable high/low phase lengths. Outputs registered.
module pulse_train_gen
    import pulse_pkg::*;
#(
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH_W-1:0] high_len,
    input  logic [WIDTH_W-1:0] low_len,
    input  logic [COUNT_W-1:0] pulse_count,
    output logic               signal,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] pulse_num
);

    state_t             state;
    logic               lat_mode;
    logic [WIDTH_W-1:0] lat_high;
    logic [WIDTH_W-1:0] lat_low;
    logic [COUNT_W-1:0] lat_count;

    logic               cfg_ok;
    logic               accept;
    logic               more;
    logic               tmr_load;
    logic [WIDTH_W-1:0] tmr_val;
    logic               tmr_en;
    logic               tmr_zero;

    // Zero-length phases, or a one-shot of zero pulses, are rejected
    assign cfg_ok = (high_len != '0) && (low_len != '0) &&
                    ((mode == MODE_CONT) || (pulse_count != '0));
    assign accept = (state == ST_IDLE) && start && !stop && cfg_ok;
    // Another pulse follows the current low phase
    assign more   = (lat_mode != MODE_ONESHOT) || (pulse_num < lat_count);
    assign tmr_en = (state != ST_IDLE);

    // Phase timer reload: new phase length on each transition, cleared on abort
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = high_len - WIDTH_W'(1);
                end
            end
            ST_HIGH: begin
                if (stop) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = lat_low - WIDTH_W'(1);
                end
            end
            ST_LOW: begin
                if (stop) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero && more) begin
                    tmr_load = 1'b1;
                    tmr_val  = lat_high - WIDTH_W'(1);
                end
            end
            default: begin
                tmr_load = 1'b1;
            end
        endcase
    end

    pulse_phase_timer #(.WIDTH_W(WIDTH_W)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .enable   (tmr_en),
        .zero     (tmr_zero)
    );

    // Train sequencing FSM with registered outputs; done/err are single-cycle strobes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            signal    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pulse_num <= '0;
            lat_mode  <= MODE_ONESHOT;
            lat_high  <= '0;
            lat_low   <= '0;
            lat_count <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (cfg_ok) begin
                            state     <= ST_HIGH;
                            signal    <= 1'b1;
                            busy      <= 1'b1;
                            pulse_num <= COUNT_W'(1);
                            lat_mode  <= mode;
                            lat_high  <= high_len;
                            lat_low   <= low_len;
                            lat_count <= pulse_count;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        signal <= 1'b0;
                        busy   <= 1'b0;
                    end else if (tmr_zero) begin
                        state  <= ST_LOW;
                        signal <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        signal <= 1'b0;
                        busy   <= 1'b0;
                    end else if (tmr_zero) begin
                        if (more) begin
                            state     <= ST_HIGH;
                            signal    <= 1'b1;
                            pulse_num <= pulse_num + COUNT_W'(1);
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    signal <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: a cycle-index reference model (position within
// the train decides the outputs) compared every cycle, plus literal waveforms.
module tb_pulse_train_gen;

    localparam int WW = 8;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [WW-1:0] high_len = '0;
    logic [WW-1:0] low_len = '0;
    logic [CW-1:0] pulse_count = '0;
    logic          signal, busy, done, err;
    logic [CW-1:0] pulse_num;

    int errors = 0;
    int checks = 0;

    pulse_train_gen #(.WIDTH_W(WW), .COUNT_W(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .high_len    (high_len),
        .low_len     (low_len),
        .pulse_count (pulse_count),
        .signal      (signal),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pulse_num   (pulse_num)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a train is "cycle k since start"; outputs follow from k
    bit      m_active = 0;
    int      m_k = 0;
    int      m_h = 0, m_l = 0, m_n = 0;
    bit      m_mode = 0;
    int      m_pnum = 0;
    bit      m_done = 0, m_err = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_k = 0; m_pnum = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_active) begin
                if (stop) begin
                    m_active = 0;
                end else begin
                    m_k++;
                    if (!m_mode && m_k == m_n * (m_h + m_l)) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_pnum = (m_k / (m_h + m_l) + 1) % (1 << CW);
                    end
                end
            end else if (start && !stop) begin
                if (high_len != 0 && low_len != 0 && (mode || pulse_count != 0)) begin
                    m_active = 1; m_k = 0; m_pnum = 1;
                    m_h = int'(high_len); m_l = int'(low_len);
                    m_n = int'(pulse_count); m_mode = mode;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    function automatic bit m_signal();
        return m_active && ((m_k % (m_h + m_l)) < m_h);
    endfunction

    // Every-cycle comparison, sampled on the falling edge
    always @(negedge clock) begin
        chk("signal", 32'(signal), 32'(m_signal()));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("pulse_num", 32'(pulse_num), 32'(m_pnum));
        chk("done_err_excl", 32'(done & err), 32'(0));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input bit md, input int h, input int l, input int n);
        mode = md;
        high_len = WW'(h);
        low_len = WW'(l);
        pulse_count = CW'(n);
    endtask

    initial begin
        logic [12:0] pat_sig;
        logic [12:0] pat_busy;
        logic [13:0] pat_cont;

        #12 reset_n = 1'b1;
        #1;
        chk("reset_signal", 32'(signal), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_pnum", 32'(pulse_num), 32'(0));
        tick();

        // One-shot 2/2 x3: literal waveform, start re-asserted mid-train
        cfg(0, 2, 2, 3);
        start = 1; tick(); start = 0;
        pat_sig  = 13'b0001100110011;
        pat_busy = 13'b0111111111111;
        for (int c = 0; c <= 12; c++) begin
            chk("t1_signal", 32'(signal), 32'(pat_sig[c]));
            chk("t1_busy", 32'(busy), 32'(pat_busy[c]));
            chk("t1_done", 32'(done), 32'(c == 12));
            if (c == 5) begin start = 1; cfg(1, 7, 7, 9); end
            if (c == 6) start = 0;
            tick();
        end
        chk("t1_pnum", 32'(pulse_num), 32'(3));

        // Asymmetric one-shot 1/5 x2
        cfg(0, 1, 5, 2);
        start = 1; tick(); start = 0;
        for (int c = 0; c <= 12; c++) begin
            chk("t2_signal", 32'(signal), 32'(c == 0 || c == 6));
            chk("t2_done", 32'(done), 32'(c == 12));
            tick();
        end

        // Continuous 3/1, stop sampled at edge 10
        cfg(1, 3, 1, 0);
        start = 1; tick(); start = 0;
        pat_cont = 14'b00001101110111;
        for (int c = 0; c <= 13; c++) begin
            chk("t3_signal", 32'(signal), 32'(pat_cont[c]));
            chk("t3_busy", 32'(busy), 32'(c < 10));
            chk("t3_done", 32'(done), 32'(0));
            if (c == 9) stop = 1;
            if (c == 10) stop = 0;
            tick();
        end
        chk("t3_pnum", 32'(pulse_num), 32'(3));

        // Invalid starts and start+stop together
        cfg(0, 0, 3, 2);
        start = 1; tick(); start = 0;
        chk("inv_h_err", 32'(err), 32'(1));
        chk("inv_h_busy", 32'(busy), 32'(0));
        tick();
        chk("inv_h_err_clr", 32'(err), 32'(0));
        cfg(0, 2, 2, 0);
        start = 1; tick(); start = 0;
        chk("inv_n_err", 32'(err), 32'(1));
        chk("inv_n_signal", 32'(signal), 32'(0));
        tick();
        cfg(0, 2, 2, 2);
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("ss_err", 32'(err), 32'(0));
        chk("ss_busy", 32'(busy), 32'(0));
        tick();

        // Asynchronous reset mid-HIGH, then a fresh train
        cfg(0, 4, 2, 2);
        start = 1; tick(); start = 0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_signal", 32'(signal), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_pnum", 32'(pulse_num), 32'(0));
        tick();
        #2 reset_n = 1'b1;
        tick();
        cfg(0, 4, 2, 1);
        start = 1; tick(); start = 0;
        for (int c = 0; c <= 6; c++) begin
            chk("rst_train_signal", 32'(signal), 32'(c < 4));
            chk("rst_train_done", 32'(done), 32'(c == 6));
            chk("rst_train_pnum", 32'(pulse_num), 32'(1));
            tick();
        end

        // Continuous 1/1 long enough to wrap pulse_num
        cfg(1, 1, 1, 0);
        start = 1; tick(); start = 0;
        repeat (530) tick();
        chk("wrap_pnum", 32'(pulse_num), 32'(266 % 256));
        stop = 1; tick(); stop = 0;
        tick();

        // Randomized traffic; config inputs churn every cycle
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 40) == 0);
            cfg(($urandom_range(0, 3) == 0), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4));
            tick();
        end
        start = 0; stop = 1; tick(); stop = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
